cla_32_adder: RTL and testbench

- 32-bit carry-lookahead adder with registered outputs.
- Computes s = a + b + c_in and the carry-out c_outfinal.
- Used as the adder leaf of the datapath/ALU. Operands are combinational inputs; results are captured on the clock so the block closes timing as a single pipeline stage.

---
 rtl/cla_32_adder_pkg.sv | 37 +++
 rtl/cla_32_adder_if.sv | 19 +
 rtl/cla_32_adder_cla_4.sv | 31 +++
 rtl/cla_32_adder.sv | 61 ++++++
 tb/tb_cla_32_adder.sv | 120 ++++++++++++
 5 files changed

// File: rtl/cla_32_adder_pkg.sv
// Shared constants, result type and lookahead helpers for the 32-bit CLA.
// The same 4-wide lookahead equations serve both the bit level (inside
// each group) and the group level (across groups).
package cla_32_adder_pkg;

    localparam int unsigned ADD_W = 32;
    localparam int unsigned GRP_W = 4;
    localparam int unsigned N_GRP = 8;

    // Registered result: carry out of bit 31 plus the 32-bit sum.
    typedef struct packed {
        logic             c;
        logic [ADD_W-1:0] s;
    } sum_t;

    // Carries into each of the four positions, with position 0 getting cin.
    // Each carry is a flat sum of products, so no position waits on another.
    function automatic logic [3:0] la_carries(input logic [3:0] g,
                                              input logic [3:0] p,
                                              input logic       cin);
        logic [3:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    // Block generate: the four positions produce a carry on their own.
    function automatic logic grp_gen(input logic [3:0] g,
                                     input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/cla_32_adder_if.sv
// Operand/result bundle for cla_32_adder.
//   a, b       : 32-bit operands
//   c_in       : carry into bit 0
//   s          : registered sum
//   c_outfinal : registered carry out of bit 31
// master drives the operands, slave (the adder) drives the results.
interface cla_32_adder_if;
    import cla_32_adder_pkg::*;

    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
    logic             c_in;
    logic [ADD_W-1:0] s;
    logic             c_outfinal;

    modport master (output a, b, c_in, input s, c_outfinal);
    modport slave  (input a, b, c_in, output s, c_outfinal);

endinterface

// File: rtl/cla_32_adder_cla_4.sv
// 4-bit carry-lookahead group.
//   a_i, b_i : 4-bit operand slices
//   cin_i    : carry into the group
//   s_o      : 4-bit sum slice
//   g_o      : group generate
//   p_o      : group propagate
module cla_4
    import cla_32_adder_pkg::*;
(
    input  logic [GRP_W-1:0] a_i,
    input  logic [GRP_W-1:0] b_i,
    input  logic             cin_i,
    output logic [GRP_W-1:0] s_o,
    output logic             g_o,
    output logic             p_o
);

    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] p;
    logic [GRP_W-1:0] c;

    always_comb begin
        g   = a_i & b_i;
        p   = a_i ^ b_i;
        c   = la_carries(g, p, cin_i);
        s_o = p ^ c;
        g_o = grp_gen(g, p);
        p_o = &p;
    end

endmodule

// File: rtl/cla_32_adder.sv
// 32-bit carry-lookahead adder, one registered pipeline stage.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears s and c_outfinal
//   bus : cla_32_adder_if.slave (a, b, c_in in; s, c_outfinal out)
// Eight cla_4 groups feed a two-block group-level lookahead; the 33-bit
// result {c_outfinal, s} is captured every clock edge.
module cla_32_adder
    import cla_32_adder_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    cla_32_adder_if.slave  bus
);

    logic [N_GRP-1:0] grp_g;
    logic [N_GRP-1:0] grp_p;
    logic [N_GRP-1:0] grp_c;
    logic [ADD_W-1:0] grp_s;
    logic             c_mid;
    logic             c_top;
    sum_t             res_d;
    sum_t             res_q;

    for (genvar k = 0; k < N_GRP; k++) begin : g_grp
        cla_4 u_cla_4 (
            .a_i   (bus.a[k*GRP_W +: GRP_W]),
            .b_i   (bus.b[k*GRP_W +: GRP_W]),
            .cin_i (grp_c[k]),
            .s_o   (grp_s[k*GRP_W +: GRP_W]),
            .g_o   (grp_g[k]),
            .p_o   (grp_p[k])
        );
    end

    // Groups 0-3 and 4-7 form two lookahead blocks. The carry into the
    // upper block and the final carry out are both expanded directly from
    // c_in, so neither block waits on a ripple through the other.
    always_comb begin
        c_mid        = grp_gen(grp_g[3:0], grp_p[3:0])
                     | (&grp_p[3:0] & bus.c_in);
        c_top        = grp_gen(grp_g[7:4], grp_p[7:4])
                     | (&grp_p[7:4] & grp_gen(grp_g[3:0], grp_p[3:0]))
                     | (&grp_p & bus.c_in);
        grp_c[3:0]   = la_carries(grp_g[3:0], grp_p[3:0], bus.c_in);
        grp_c[7:4]   = la_carries(grp_g[7:4], grp_p[7:4], c_mid);
        res_d.c      = c_top;
        res_d.s      = grp_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign bus.s          = res_q.s;
    assign bus.c_outfinal = res_q.c;

endmodule

// File: tb/tb_cla_32_adder.sv
// Directed bench for cla_32_adder: reset, hand-computed vectors including
// carry-chain boundaries, input hold between edges, mid-stream reset, and
// a random sweep against a 33-bit behavioural sum.
module tb_cla_32_adder;

    logic clk;
    logic rst;
    int unsigned n_vec;
    int unsigned n_bad;

    cla_32_adder_if bus ();

    cla_32_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag,
                            input logic [32:0] obs,
                            input logic [32:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got {c,s}=%h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge capture, sample 1 ns later.
    task automatic run_vec(input string tag,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic        ci,
                           input logic [31:0] exp_s,
                           input logic        exp_c);
        @(negedge clk);
        bus.a    = a;
        bus.b    = b;
        bus.c_in = ci;
        @(posedge clk);
        #1;
        check_eq(tag, {bus.c_outfinal, bus.s}, {exp_c, exp_s});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] rexp;

        n_vec    = 0;
        n_bad    = 0;
        bus.a    = 32'h0;
        bus.b    = 32'h0;
        bus.c_in = 1'b0;
        rst      = 1'b1;

        // Reset holds outputs low even with live operands across an edge.
        #2;
        check_eq("reset_async", {bus.c_outfinal, bus.s}, 33'h0);
        @(negedge clk);
        bus.a = 32'hFFFFFFFF;
        bus.b = 32'h00000001;
        @(posedge clk);
        #1;
        check_eq("reset_hold", {bus.c_outfinal, bus.s}, 33'h0);
        @(negedge clk);
        rst = 1'b0;

        run_vec("small",        32'h00000000, 32'h00000004, 1'b0, 32'h00000004, 1'b0);
        run_vec("wrap_all_one", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
        run_vec("cin_cross",    32'h0000FFFF, 32'h00000000, 1'b1, 32'h00010000, 1'b0);
        run_vec("max_sum",      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
        run_vec("cin_prop_all", 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1);
        run_vec("prop_no_cin",  32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0);
        run_vec("msb_carry",    32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1);
        run_vec("signed_edge",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0);
        run_vec("grp0_out",     32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0);
        run_vec("grp6_out",     32'h0FFFFFFF, 32'h00000000, 1'b1, 32'h10000000, 1'b0);
        run_vec("upper_wrap",   32'hFFFF0000, 32'h00010000, 1'b0, 32'h00000000, 1'b1);
        run_vec("mixed",        32'h12345678, 32'h0F0F0F0F, 1'b1, 32'h21436588, 1'b0);

        // Operands changing between edges must not reach the outputs.
        #2;
        bus.a = 32'h00000001;
        bus.b = 32'h00000001;
        #2;
        check_eq("hold_between", {bus.c_outfinal, bus.s}, {1'b0, 32'h21436588});

        // Mid-stream reset: clears immediately, next edge after release loads.
        @(negedge clk);
        bus.a    = 32'h12345678;
        bus.b    = 32'h87654321;
        bus.c_in = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_clear", {bus.c_outfinal, bus.s}, 33'h0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_load", {bus.c_outfinal, bus.s}, {1'b0, 32'h99999999});

        for (int i = 0; i < 10000; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rc   = 1'($urandom_range(0, 1));
            rexp = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            run_vec("random", ra, rb, rc, rexp[31:0], rexp[32]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
